sif_wa_bridge: RTL and testbench

SIF_WA_BRIDGE -- requirements
Module: sif_wa_bridge

---
 rtl/sif_pkg.sv | 22 ++
 rtl/sif_fifo.sv | 81 ++++++++
 rtl/sif_wa_bridge.sv | 88 ++++++++
 tb/tb_sif_wa_bridge.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sif_pkg.sv
// sif_pkg -- shared definitions for the XA/WA bridge.
//   xa_op_e    : decode of {xa_wr_s, xa_rd_s}
//   SIF_DATA_W : default XA/WA data width
//   SIF_DEPTH  : default FIFO depth (power of two, 2..16)
package sif_pkg;

    localparam int unsigned SIF_DATA_W = 16;
    localparam int unsigned SIF_DEPTH  = 8;

    // Encoding matches the raw strobe pair {xa_wr_s, xa_rd_s}.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        READ    = 2'b01,
        WRITE   = 2'b10,
        ILLEGAL = 2'b11
    } xa_op_e;

    function automatic xa_op_e decode_op(input logic wr_s, input logic rd_s);
        return xa_op_e'({wr_s, rd_s});
    endfunction

endpackage

// File: rtl/sif_fifo.sv
// sif_fifo -- first-word fall-through FIFO with registered occupancy flags.
//   clk, rst  : clock, synchronous active-high reset
//   push      : push request (dropped when full unless a pop occurs the same cycle)
//   pop       : pop request (ignored when empty)
//   din       : push data
//   dout      : head entry, 0 while empty
//   accepted  : push request is taken this cycle
//   count     : occupancy, 0..DEPTH
//   full      : count == DEPTH
//   empty     : count == 0
module sif_fifo
    import sif_pkg::*;
#(
    parameter int unsigned DEPTH  = SIF_DEPTH,
    parameter int unsigned DATA_W = SIF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_W-1:0]       din,
    output logic [DATA_W-1:0]       dout,
    output logic                    accepted,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full,
    output logic                    empty
);

    localparam int unsigned   AW       = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_nxt;
    logic              do_push;
    logic              do_pop;

    // A pop in the same cycle frees the slot, so a full FIFO may still take a push.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        count_nxt = count;
        if (do_push && !do_pop) begin
            count_nxt = count + 1'b1;
        end else if (do_pop && !do_push) begin
            count_nxt = count - 1'b1;
        end
    end

    assign accepted = do_push;
    assign dout     = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/sif_wa_bridge.sv
// sif_wa_bridge -- XA strobe interface to WA valid/ready stream via a FIFO.
//   clk, rst     : clock, synchronous active-high reset
//   xa_wr_s      : XA write strobe
//   xa_rd_s      : XA read strobe (returns the last written value)
//   xa_data_in   : XA write data
//   xa_data_out  : XA read data, held between reads
//   xa_rd_valid  : one-cycle pulse, xa_data_out updated
//   xa_err       : one-cycle pulse on overflow or both strobes high
//   wa_data      : FIFO head (first-word fall-through)
//   wa_valid     : FIFO not empty
//   wa_ready     : WA consumer accepts the head
//   fifo_count   : FIFO occupancy
//   fifo_full    : occupancy flag
//   fifo_empty   : occupancy flag
module sif_wa_bridge
    import sif_pkg::*;
#(
    parameter int unsigned DEPTH  = SIF_DEPTH,
    parameter int unsigned DATA_W = SIF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    xa_wr_s,
    input  logic                    xa_rd_s,
    input  logic [DATA_W-1:0]       xa_data_in,
    output logic [DATA_W-1:0]       xa_data_out,
    output logic                    xa_rd_valid,
    output logic                    xa_err,
    output logic [DATA_W-1:0]       wa_data,
    output logic                    wa_valid,
    input  logic                    wa_ready,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    fifo_full,
    output logic                    fifo_empty
);

    xa_op_e            op;
    logic              push;
    logic              pop;
    logic              accepted;
    logic              err_nxt;
    logic [DATA_W-1:0] shadow;

    always_comb begin
        op      = decode_op(xa_wr_s, xa_rd_s);
        push    = (op == WRITE);
        pop     = wa_ready && !fifo_empty;
        // Overflow is a write the FIFO refused (full with no concurrent pop).
        err_nxt = (op == ILLEGAL) || (push && !accepted);
    end

    assign wa_valid = !fifo_empty;

    sif_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .din      (xa_data_in),
        .dout     (wa_data),
        .accepted (accepted),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= '0;
            xa_data_out <= '0;
            xa_rd_valid <= 1'b0;
            xa_err      <= 1'b0;
        end else begin
            if (accepted) begin
                shadow <= xa_data_in;
            end
            if (op == READ) begin
                xa_data_out <= shadow;
            end
            xa_rd_valid <= (op == READ);
            xa_err      <= err_nxt;
        end
    end

endmodule

// File: tb/tb_sif_wa_bridge.sv
// tb_sif_wa_bridge -- directed scoreboard bench for sif_wa_bridge.
// Inputs are driven and outputs sampled on the falling edge; a queue holds
// the expected WA stream and is popped whenever the bench completes a handshake.
module tb_sif_wa_bridge;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              xa_wr_s;
    logic              xa_rd_s;
    logic [DATA_W-1:0] xa_data_in;
    logic [DATA_W-1:0] xa_data_out;
    logic              xa_rd_valid;
    logic              xa_err;
    logic [DATA_W-1:0] wa_data;
    logic              wa_valid;
    logic              wa_ready;
    logic [3:0]        fifo_count;
    logic              fifo_full;
    logic              fifo_empty;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state
    logic [DATA_W-1:0] sb_q[$];
    logic [DATA_W-1:0] m_shadow;
    logic [DATA_W-1:0] m_dout;
    logic              m_rdv;
    logic              m_err;

    always #5 clk = ~clk;

    sif_wa_bridge #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .xa_wr_s     (xa_wr_s),
        .xa_rd_s     (xa_rd_s),
        .xa_data_in  (xa_data_in),
        .xa_data_out (xa_data_out),
        .xa_rd_valid (xa_rd_valid),
        .xa_err      (xa_err),
        .wa_data     (wa_data),
        .wa_valid    (wa_valid),
        .wa_ready    (wa_ready),
        .fifo_count  (fifo_count),
        .fifo_full   (fifo_full),
        .fifo_empty  (fifo_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against the reference state for the current cycle.
    task automatic check_state(input string tag);
        int unsigned n;
        logic [DATA_W-1:0] head;
        n = sb_q.size();
        head = (n != 0) ? sb_q[0] : '0;
        chk({tag, ".count"},    32'(fifo_count),  32'(n));
        chk({tag, ".full"},     32'(fifo_full),   32'(n == DEPTH));
        chk({tag, ".empty"},    32'(fifo_empty),  32'(n == 0));
        chk({tag, ".wa_valid"}, 32'(wa_valid),    32'(n != 0));
        chk({tag, ".wa_data"},  32'(wa_data),     32'(head));
        chk({tag, ".rd_valid"}, 32'(xa_rd_valid), 32'(m_rdv));
        chk({tag, ".data_out"}, 32'(xa_data_out), 32'(m_dout));
        chk({tag, ".err"},      32'(xa_err),      32'(m_err));
    endtask

    // One clock cycle: check outputs, drive inputs, advance the model, clock.
    task automatic step(input string tag, input logic r, input logic wr, input logic rd,
                        input logic [DATA_W-1:0] d, input logic rdy);
        logic pop;
        logic push_ok;
        logic [DATA_W-1:0] popped;
        check_state(tag);
        rst        = r;
        xa_wr_s    = wr;
        xa_rd_s    = rd;
        xa_data_in = d;
        wa_ready   = rdy;
        if (r) begin
            sb_q.delete();
            m_shadow = '0;
            m_dout   = '0;
            m_rdv    = 1'b0;
            m_err    = 1'b0;
        end else begin
            pop     = rdy && (sb_q.size() != 0);
            push_ok = wr && !rd && ((sb_q.size() < DEPTH) || pop);
            if (pop) begin
                popped = sb_q.pop_front();
                chk({tag, ".pop"}, 32'(wa_data), 32'(popped));
            end
            m_rdv = !wr && rd;
            if (m_rdv) m_dout = m_shadow;
            m_err = (wr && rd) || (wr && !rd && !push_ok);
            if (push_ok) begin
                sb_q.push_back(d);
                m_shadow = d;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; xa_wr_s = 1'b0; xa_rd_s = 1'b0; xa_data_in = '0; wa_ready = 1'b0;
        sb_q.delete();
        m_shadow = '0; m_dout = '0; m_rdv = 1'b0; m_err = 1'b0;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);

        // Single word through an empty FIFO; first cycle with rst low is honoured.
        step("w_a5a5",   1'b0, 1'b1, 1'b0, 16'hA5A5, 1'b1);
        step("pop_a5a5", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("empty_a",  1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        step("empty_rdy",1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Fill to full, ninth write overflows.
        for (int i = 1; i <= 9; i++) begin
            step($sformatf("fill%0d", i), 1'b0, 1'b1, 1'b0, 16'(i), 1'b0);
        end
        step("full_hold", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        // Write while full with concurrent pop: accepted, no error.
        step("full_wpop", 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step($sformatf("drain%0d", i), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        end

        // Shadow read-back and illegal op.
        step("w_1234",  1'b0, 1'b1, 1'b0, 16'h1234, 1'b0);
        step("rd",      1'b0, 1'b0, 1'b1, 16'h0000, 1'b0);
        step("rd_idle", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("illegal", 1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0);
        step("ill_idle",1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step("hold",    1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Interleaved traffic across pointer wrap with random back-pressure.
        for (int i = 0; i < 20; i++) begin
            step($sformatf("mix%0d", i), 1'b0, 1'b1, 1'b0, 16'(16'h0100 + i),
                 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0)
                step($sformatf("mixi%0d", i), 1'b0, 1'b0, 1'b0, 16'h0000,
                     1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            step($sformatf("mixd%0d", i), 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        end

        // Reset mid-operation with a concurrent write.
        for (int i = 0; i < 4; i++) begin
            step($sformatf("pre%0d", i), 1'b0, 1'b1, 1'b0, 16'(16'h0A00 + i), 1'b0);
        end
        step("rst_mid",  1'b1, 1'b1, 1'b0, 16'hBEEF, 1'b0);
        step("post_rd",  1'b0, 1'b0, 1'b1, 16'h0000, 1'b1);
        step("post_w",   1'b0, 1'b1, 1'b0, 16'h5A5A, 1'b0);
        step("post_end", 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1);
        check_state("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
